// File: rtl/dist_pkg.sv
// Shared types and constants for the echo distance filter.
// Holds the FSM state encoding, the centimetre value type, and the range limits.
package dist_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_DIV, ST_AVG, ST_OUT} dist_st_t;

    typedef logic [9:0] cm_t;

    localparam logic [6:0] US_PER_CM = 7'd58;
    localparam cm_t        MIN_CM    = 10'd2;
    localparam cm_t        MAX_CM    = 10'd400;
    localparam int         AVG_LOG2  = 2;
    localparam int         AVG_DEPTH = 1 << AVG_LOG2;

endpackage

// File: rtl/seq_div16.sv
// 16-bit by constant restoring divider, one quotient bit per cycle, MSB first.
// Latency: start, then 16 cycles; done_o is high in the last one and quotient_o is valid the cycle after. start_i restarts it.
module seq_div16 #(
    parameter logic [6:0] DIVISOR = 7'd58
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [15:0] dividend_i,
    output logic [15:0] quotient_o,
    output logic        done_o
);

    logic [15:0] acc_q, acc_d;
    logic [6:0]  rem_q, rem_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        run_q, run_d;
    logic [7:0]  trial;
    logic [7:0]  diff;
    logic        fits;

    // acc_q shifts the dividend out of the top while quotient bits enter at the bottom
    always_comb begin
        acc_d = acc_q;
        rem_d = rem_q;
        cnt_d = cnt_q;
        run_d = run_q;
        trial = {rem_q, acc_q[15]};
        diff  = trial - {1'b0, DIVISOR};
        fits  = (trial >= {1'b0, DIVISOR});
        if (start_i) begin
            acc_d = dividend_i;
            rem_d = 7'd0;
            cnt_d = 4'd0;
            run_d = 1'b1;
        end else if (run_q) begin
            acc_d = {acc_q[14:0], fits};
            rem_d = fits ? diff[6:0] : trial[6:0];
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
                run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= 16'd0;
            rem_q <= 7'd0;
            cnt_q <= 4'd0;
            run_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            rem_q <= rem_d;
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

    assign done_o     = run_q && (cnt_q == 4'd15);
    assign quotient_o = acc_q;

endmodule

// File: rtl/echo_dist_filter.sv
// Echo width (us) -> cm via sequential divide, 4-sample moving average, range/timeout flagging.
// Latency 18 cycles per measurement (1 for timeout); strobes arriving while busy are dropped and flagged on overrun.
module echo_dist_filter
    import dist_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] meas_us,
    input  logic        meas_valid,
    input  logic        meas_timeout,
    output logic [9:0]  dist_cm,
    output logic        dist_valid,
    output logic        dist_err,
    output logic        busy,
    output logic        overrun
);

    dist_st_t    state_q, state_d;
    cm_t         cm_q, cm_d;
    logic        err_q, err_d;
    logic        ovr_q, ovr_d;
    cm_t         buf_q [AVG_DEPTH];
    cm_t         buf_d [AVG_DEPTH];
    logic [1:0]  wp_q, wp_d;
    logic        empty_q, empty_d;
    logic        div_start;
    logic        div_done;
    logic [15:0] quo;
    logic [11:0] sum4;
    logic [11:0] sum4_rnd;

    seq_div16 #(
        .DIVISOR (US_PER_CM)
    ) u_div (
        .clk        (clk),
        .rst        (rst),
        .start_i    (div_start),
        .dividend_i (meas_us),
        .quotient_o (quo),
        .done_o     (div_done)
    );

    always_comb begin
        state_d   = state_q;
        cm_d      = cm_q;
        err_d     = err_q;
        wp_d      = wp_q;
        empty_d   = empty_q;
        buf_d     = buf_q;
        div_start = 1'b0;
        sum4      = 12'd0;
        sum4_rnd  = 12'd0;
        ovr_d     = (state_q != ST_IDLE) && (meas_valid || meas_timeout);
        case (state_q)
            ST_IDLE: begin
                if (meas_timeout) begin
                    err_d   = 1'b1;
                    empty_d = 1'b1;
                    state_d = ST_OUT;
                end else if (meas_valid) begin
                    div_start = 1'b1;
                    state_d   = ST_DIV;
                end
            end
            ST_DIV: begin
                if (div_done) begin
                    state_d = ST_AVG;
                end
            end
            ST_AVG: begin
                state_d = ST_OUT;
                if (quo < {6'd0, MIN_CM}) begin
                    err_d   = 1'b1;
                    empty_d = 1'b1;
                end else if (quo > {6'd0, MAX_CM}) begin
                    err_d   = 1'b1;
                    cm_d    = MAX_CM;
                    empty_d = 1'b1;
                end else begin
                    err_d   = 1'b0;
                    empty_d = 1'b0;
                    // First good sample after an error seeds the whole window
                    if (empty_q) begin
                        for (int i = 0; i < AVG_DEPTH; i++) begin
                            buf_d[i] = quo[9:0];
                        end
                        wp_d = 2'd1;
                    end else begin
                        buf_d[wp_q] = quo[9:0];
                        wp_d        = wp_q + 2'd1;
                    end
                    for (int i = 0; i < AVG_DEPTH; i++) begin
                        sum4 = sum4 + {2'd0, buf_d[i]};
                    end
                    sum4_rnd = sum4 + 12'd2;
                    cm_d     = sum4_rnd[11:2];
                end
            end
            ST_OUT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cm_q    <= '0;
            err_q   <= 1'b0;
            ovr_q   <= 1'b0;
            wp_q    <= 2'd0;
            empty_q <= 1'b1;
            for (int i = 0; i < AVG_DEPTH; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cm_q    <= cm_d;
            err_q   <= err_d;
            ovr_q   <= ovr_d;
            wp_q    <= wp_d;
            empty_q <= empty_d;
            buf_q   <= buf_d;
        end
    end

    assign dist_cm    = cm_q;
    assign dist_err   = err_q;
    assign dist_valid = (state_q == ST_OUT);
    assign busy       = (state_q != ST_IDLE);
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_echo_dist_filter.sv
// Directed table-driven bench for echo_dist_filter plus overrun and mid-division reset sequences.
module tb_echo_dist_filter;

    typedef enum {K_VAL, K_TO, K_BOTH} kind_t;

    typedef struct {
        kind_t       kind;
        logic [15:0] us;
        int          exp_lat;
        logic [9:0]  exp_cm;
        logic        exp_err;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [15:0] meas_us;
    logic        meas_valid;
    logic        meas_timeout;
    logic [9:0]  dist_cm;
    logic        dist_valid;
    logic        dist_err;
    logic        busy;
    logic        overrun;

    int n_vec;
    int n_err;

    vec_t vecs [19];

    echo_dist_filter dut (
        .clk          (clk),
        .rst          (rst),
        .meas_us      (meas_us),
        .meas_valid   (meas_valid),
        .meas_timeout (meas_timeout),
        .dist_cm      (dist_cm),
        .dist_valid   (dist_valid),
        .dist_err     (dist_err),
        .busy         (busy),
        .overrun      (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        int extra;
        logic [9:0] cm_seen;
        logic       err_seen;
        lat      = 0;
        extra    = 0;
        cm_seen  = '0;
        err_seen = 1'b0;
        @(negedge clk);
        meas_us      = v.us;
        meas_valid   = (v.kind != K_TO);
        meas_timeout = (v.kind != K_VAL);
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            meas_valid   = 1'b0;
            meas_timeout = 1'b0;
            if (dist_valid) begin
                lat      = c;
                cm_seen  = dist_cm;
                err_seen = dist_err;
                break;
            end
        end
        check($sformatf("v%0d latency", idx), lat, v.exp_lat);
        check($sformatf("v%0d dist_cm", idx), int'(cm_seen), int'(v.exp_cm));
        check($sformatf("v%0d dist_err", idx), int'(err_seen), int'(v.exp_err));
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (dist_valid) extra++;
        end
        check($sformatf("v%0d extra dist_valid", idx), extra, 0);
        check($sformatf("v%0d busy after", idx), int'(busy), 0);
    endtask

    initial begin
        int first_v;
        int n_valid;
        int cm_at_valid;

        n_vec = 0;
        n_err = 0;

        // Buffer state carries from row to row
        vecs[0]  = '{K_VAL,  16'd580,   18, 10'd10,  1'b0};
        vecs[1]  = '{K_VAL,  16'd1160,  18, 10'd13,  1'b0};
        vecs[2]  = '{K_VAL,  16'd1160,  18, 10'd15,  1'b0};
        vecs[3]  = '{K_VAL,  16'd1160,  18, 10'd18,  1'b0};
        vecs[4]  = '{K_VAL,  16'd1160,  18, 10'd20,  1'b0};
        vecs[5]  = '{K_TO,   16'd0,     1,  10'd20,  1'b1};
        vecs[6]  = '{K_VAL,  16'd580,   18, 10'd10,  1'b0};
        vecs[7]  = '{K_VAL,  16'd60,    18, 10'd10,  1'b1};
        vecs[8]  = '{K_VAL,  16'd30000, 18, 10'd400, 1'b1};
        vecs[9]  = '{K_VAL,  16'd0,     18, 10'd400, 1'b1};
        vecs[10] = '{K_VAL,  16'hFFFF,  18, 10'd400, 1'b1};
        vecs[11] = '{K_VAL,  16'd116,   18, 10'd2,   1'b0};
        vecs[12] = '{K_VAL,  16'd23200, 18, 10'd102, 1'b0};
        vecs[13] = '{K_VAL,  16'd23258, 18, 10'd400, 1'b1};
        vecs[14] = '{K_BOTH, 16'd580,   1,  10'd400, 1'b1};
        vecs[15] = '{K_VAL,  16'd115,   18, 10'd400, 1'b1};
        vecs[16] = '{K_VAL,  16'd57,    18, 10'd400, 1'b1};
        vecs[17] = '{K_VAL,  16'd1739,  18, 10'd29,  1'b0};
        vecs[18] = '{K_VAL,  16'd1740,  18, 10'd29,  1'b0};

        rst          = 1'b1;
        meas_us      = '0;
        meas_valid   = 1'b0;
        meas_timeout = 1'b0;
        repeat (3) @(negedge clk);
        check("reset outputs", int'({dist_cm, dist_valid, dist_err, busy, overrun}), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("post-reset outputs", int'({dist_cm, dist_valid, dist_err, busy, overrun}), 0);

        for (int i = 0; i < 19; i++) begin
            run_vec(vecs[i], i);
        end

        // Second strobe at N+5 is dropped: overrun at N+6, single result for the first sample
        first_v     = 0;
        n_valid     = 0;
        cm_at_valid = -1;
        @(negedge clk);
        meas_us    = 16'd580;
        meas_valid = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            meas_valid = 1'b0;
            if (i == 2) check("busy during div", int'(busy), 1);
            if (i == 5) begin
                meas_us    = 16'd30000;
                meas_valid = 1'b1;
            end
            if (i == 6) check("overrun at N+6", int'(overrun), 1);
            if (i == 7) check("overrun cleared N+7", int'(overrun), 0);
            if (dist_valid) begin
                n_valid++;
                if (first_v == 0) begin
                    first_v     = i;
                    cm_at_valid = int'(dist_cm);
                end
            end
        end
        check("ovr seq latency", first_v, 18);
        check("ovr seq dist_valid count", n_valid, 1);
        check("ovr seq dist_cm", cm_at_valid, 25);

        // Reset in the middle of a division: no result may appear
        n_valid = 0;
        @(negedge clk);
        meas_us    = 16'd1160;
        meas_valid = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            meas_valid = 1'b0;
            if (i == 8) rst = 1'b1;
            if (i == 9) begin
                check("mid-div reset outputs",
                      int'({dist_cm, dist_valid, dist_err, busy, overrun}), 0);
                rst = 1'b0;
            end
            if (dist_valid) n_valid++;
        end
        check("mid-div reset dist_valid count", n_valid, 0);

        run_vec('{K_VAL, 16'd580, 18, 10'd10, 1'b0}, 19);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
